// File: rtl/engine_accumulator.sv
// engine_accumulator: sums a configurable number of 4-lane engine chunk
// results per tile into saturating per-lane accumulators and presents the
// finished tile on a valid/ready output port.
module engine_accumulator #(
    parameter int LANES      = 4,
    parameter int IN_WIDTH   = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int MAX_CHUNKS = 16,
    parameter int CW         = $clog2(MAX_CHUNKS + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CW-1:0]                cfg_chunks,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*IN_WIDTH-1:0]    in_result,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*ACC_WIDTH-1:0]   out_data,
    output logic [LANES-1:0]             out_sat,
    output logic                         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                              state_q;
    logic [LANES-1:0][ACC_WIDTH-1:0]     acc_q;
    logic [LANES-1:0][ACC_WIDTH-1:0]     acc_d;
    logic [LANES-1:0]                    sat_q;
    logic [LANES-1:0]                    sat_d;
    logic [CW-1:0]                       cnt_q;
    logic [CW-1:0]                       cnt_inc;
    logic [CW-1:0]                       n_tile_q;
    logic [CW-1:0]                       n_cfg;
    logic                                accept;
    logic                                start;

    // In HOLD the slot frees up only as the tile leaves, so ready follows out_ready.
    assign in_ready  = (state_q != HOLD) || out_ready;
    assign accept    = in_valid && in_ready;
    // Any beat accepted outside ACCUM opens a new tile (from IDLE or overlapping delivery).
    assign start     = accept && (state_q != ACCUM);
    assign cnt_inc   = cnt_q + CW'(1);

    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign out_data  = acc_q;
    assign out_sat   = sat_q;

    // Clamp the requested chunk count into 1..MAX_CHUNKS.
    always_comb begin
        n_cfg = cfg_chunks;
        if (cfg_chunks == '0) begin
            n_cfg = CW'(1);
        end else if (cfg_chunks > CW'(MAX_CHUNKS)) begin
            n_cfg = CW'(MAX_CHUNKS);
        end
    end

    // Per-lane saturating add; a tile's first beat adds onto zero.
    always_comb begin
        acc_d = acc_q;
        sat_d = start ? '0 : sat_q;
        for (int unsigned j = 0; j < LANES; j++) begin
            logic [ACC_WIDTH:0] base_w;
            logic [ACC_WIDTH:0] sum_w;
            base_w = start ? '0 : {1'b0, acc_q[j]};
            sum_w  = base_w + {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}},
                               in_result[j*IN_WIDTH +: IN_WIDTH]};
            if (sum_w[ACC_WIDTH]) begin
                acc_d[j] = '1;
                sat_d[j] = 1'b1;
            end else begin
                acc_d[j] = sum_w[ACC_WIDTH-1:0];
            end
        end
    end

    // Tile FSM: collects n_tile beats, then holds the result until delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            sat_q    <= '0;
            cnt_q    <= '0;
            n_tile_q <= CW'(1);
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (accept) begin
                        acc_q    <= acc_d;
                        sat_q    <= sat_d;
                        cnt_q    <= CW'(1);
                        n_tile_q <= n_cfg;
                        state_q  <= (n_cfg == CW'(1)) ? HOLD : ACCUM;
                    end else if (state_q == HOLD && out_ready) begin
                        state_q <= IDLE;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        sat_q <= sat_d;
                        cnt_q <= cnt_inc;
                        if (cnt_inc == n_tile_q) begin
                            state_q <= HOLD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
